// File: rtl/rgu_result_reader.sv
// rgu_result_reader: circular FIFO that captures RGU result pushes and serves them over the UART register bus.
// Optional threshold interrupt (oIrq output, writable THRESH register) is enabled by defining RGU_RESULT_IRQ_EN.
module rgu_result_reader #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter logic [7:0] BASE  = 8'h40
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iFifoPush,
  input  logic [31:0] iFifoData,
  input  logic        iUartSelected,
  input  logic        iUartWrite,
  input  logic [7:0]  iUartAddr,
  input  logic [31:0] iUartData,
  output logic [31:0] oUartData,
  output logic        oEmpty,
  output logic        oFull,
  output logic        oOverflow
`ifdef RGU_RESULT_IRQ_EN
  ,
  output logic        oIrq
`endif
);

  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [1:0]    REG_DATA = 2'd0;
  localparam logic [1:0]    REG_STAT = 2'd1;
  localparam logic [1:0]    REG_CTRL = 2'd2;
  localparam logic [1:0]    REG_THR  = 2'd3;

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [CW-1:0] count_r;
  logic [7:0]    dropCnt_r;
  logic          sel_q;
  logic [7:0]    addr_q;

  logic [7:0]    offset_s;
  logic [1:0]    regSel_s;
  logic          hit_s;
  logic          first_s;
  logic          rdStart_s;
  logic          wrCtrl_s;
  logic          flush_s;
  logic          clear_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [AW-1:0] wpNxt_s;
  logic [AW-1:0] rpNxt_s;
  logic [CW-1:0] countNxt_s;
  logic [7:0]    dropNxt_s;
  logic          ovfNxt_s;
  logic [5:0]    countField_s;
  logic [31:0]   rdData_s;
  logic          unusedUart_s;

`ifdef RGU_RESULT_IRQ_EN
  logic [CW-1:0] thresh_r;
  logic [CW-1:0] threshNxt_s;
`endif

  // Only the low control bits (and THRESH bits when enabled) carry meaning on the write bus.
  assign unusedUart_s = ^iUartData;

  // Bus decode, pop/push arbitration and next-state computation.
  always_comb begin
    offset_s     = iUartAddr - BASE;
    regSel_s     = offset_s[1:0];
    countField_s = 6'(count_r);
    full_s       = (count_r == DEPTH_C);

    if (iUartSelected && (offset_s < 8'd4)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end

    // A read acts only on the first cycle of an access, so a held select pops once.
    if (iUartSelected && (!sel_q || (iUartAddr != addr_q))) begin
      first_s = 1'b1;
    end else begin
      first_s = 1'b0;
    end

    rdStart_s = hit_s && !iUartWrite && first_s;
    wrCtrl_s  = hit_s && iUartWrite && (regSel_s == REG_CTRL);
    flush_s   = wrCtrl_s && iUartData[0];
    clear_s   = wrCtrl_s && iUartData[1];
    pop_s     = rdStart_s && (regSel_s == REG_DATA) && (count_r != '0);
    push_s    = iFifoPush && !flush_s && (!full_s || pop_s);
    drop_s    = iFifoPush && !flush_s && full_s && !pop_s;

    if (flush_s) begin
      wpNxt_s    = '0;
      rpNxt_s    = '0;
      countNxt_s = '0;
    end else begin
      wpNxt_s = push_s ? (wp_r + PTR_ONE) : wp_r;
      rpNxt_s = pop_s ? (rp_r + PTR_ONE) : rp_r;
      if (push_s && !pop_s) begin
        countNxt_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        countNxt_s = count_r - CNT_ONE;
      end else begin
        countNxt_s = count_r;
      end
    end

    if (clear_s) begin
      dropNxt_s = 8'd0;
      ovfNxt_s  = 1'b0;
    end else if (drop_s) begin
      dropNxt_s = (dropCnt_r == 8'hFF) ? dropCnt_r : (dropCnt_r + 8'd1);
      ovfNxt_s  = 1'b1;
    end else begin
      dropNxt_s = dropCnt_r;
      ovfNxt_s  = oOverflow;
    end

    case (regSel_s)
      REG_DATA: begin
        if (count_r != '0) begin
          rdData_s = mem_r[rp_r];
        end else begin
          rdData_s = 32'd0;
        end
      end
      REG_STAT: rdData_s = {16'd0, dropCnt_r, countField_s, oOverflow, oFull};
      REG_CTRL: rdData_s = 32'd0;
`ifdef RGU_RESULT_IRQ_EN
      REG_THR:  rdData_s = 32'(thresh_r);
`else
      REG_THR:  rdData_s = 32'd0;
`endif
      default:  rdData_s = 32'd0;
    endcase

`ifdef RGU_RESULT_IRQ_EN
    if (hit_s && iUartWrite && (regSel_s == REG_THR)) begin
      threshNxt_s = iUartData[AW:0];
    end else begin
      threshNxt_s = thresh_r;
    end
`endif
  end

  // Storage array is deliberately left unreset; only accepted pushes write it.
  always_ff @(posedge iClock) begin
    if (push_s) begin
      mem_r[wp_r] <= iFifoData;
    end
  end

  // Pointers, counters, access tracking and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wp_r      <= '0;
      rp_r      <= '0;
      count_r   <= '0;
      dropCnt_r <= 8'd0;
      sel_q     <= 1'b0;
      addr_q    <= 8'd0;
      oUartData <= 32'd0;
      oEmpty    <= 1'b1;
      oFull     <= 1'b0;
      oOverflow <= 1'b0;
`ifdef RGU_RESULT_IRQ_EN
      thresh_r  <= CW'(DEPTH / 2);
      oIrq      <= 1'b0;
`endif
    end else begin
      wp_r      <= wpNxt_s;
      rp_r      <= rpNxt_s;
      count_r   <= countNxt_s;
      dropCnt_r <= dropNxt_s;
      sel_q     <= iUartSelected;
      addr_q    <= iUartAddr;
      oEmpty    <= (countNxt_s == '0);
      oFull     <= (countNxt_s == DEPTH_C);
      oOverflow <= ovfNxt_s;
      if (rdStart_s) begin
        oUartData <= rdData_s;
      end
`ifdef RGU_RESULT_IRQ_EN
      thresh_r  <= threshNxt_s;
      oIrq      <= (threshNxt_s != '0) && (countNxt_s >= threshNxt_s);
`endif
    end
  end

endmodule

// File: tb/tb_rgu_result_reader.sv
// Self-checking bench for rgu_result_reader: directed scenarios plus randomized traffic against a queue model.
module tb_rgu_result_reader;
  localparam int         DEPTH  = 16;
  localparam int         AW     = 4;
  localparam logic [7:0] A_DATA = 8'h40;
  localparam logic [7:0] A_STAT = 8'h41;
  localparam logic [7:0] A_CTRL = 8'h42;
  localparam logic [7:0] A_THR  = 8'h43;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iFifoPush = 1'b0;
  logic [31:0] iFifoData = 32'd0;
  logic        iUartSelected = 1'b0;
  logic        iUartWrite = 1'b0;
  logic [7:0]  iUartAddr = 8'd0;
  logic [31:0] iUartData = 32'd0;
  logic [31:0] oUartData;
  logic        oEmpty;
  logic        oFull;
  logic        oOverflow;
`ifdef RGU_RESULT_IRQ_EN
  logic        oIrq;
`endif

  rgu_result_reader #(.DEPTH(DEPTH), .AW(AW), .BASE(8'h40)) dut (
    .iClock(iClock), .iReset(iReset), .iFifoPush(iFifoPush), .iFifoData(iFifoData),
    .iUartSelected(iUartSelected), .iUartWrite(iUartWrite), .iUartAddr(iUartAddr),
    .iUartData(iUartData), .oUartData(oUartData), .oEmpty(oEmpty), .oFull(oFull),
    .oOverflow(oOverflow)
`ifdef RGU_RESULT_IRQ_EN
    , .oIrq(oIrq)
`endif
  );

  always #5 iClock = ~iClock;

  int nVec  = 0;
  int nFail = 0;

  // Behavioural model state
  logic [31:0] q[$];
  bit          mOvf;
  int          mDrop;
  int          mThresh;
  logic [31:0] mData;
  bit          prevSel;
  logic [7:0]  prevAddr;

  task automatic model_reset();
    q.delete();
    mOvf = 1'b0; mDrop = 0; mThresh = DEPTH / 2; mData = 32'd0;
    prevSel = 1'b0; prevAddr = 8'd0;
  endtask

  // One clock of stimulus; the model is advanced after the edge, outputs are stable at return.
  task automatic step(input bit push, input logic [31:0] pdata, input bit sel, input bit wr,
                      input logic [7:0] addr, input logic [31:0] wdata);
    bit hit, first, doPop, full, isCtrl;
    int off;
    iFifoPush = push; iFifoData = pdata; iUartSelected = sel; iUartWrite = wr;
    iUartAddr = addr; iUartData = wdata;
    off    = int'(addr) - 'h40;
    hit    = sel && off >= 0 && off <= 3;
    first  = sel && (!prevSel || addr != prevAddr);
    full   = (q.size() == DEPTH);
    isCtrl = hit && wr && off == 2;
    doPop  = 1'b0;
    if (hit && !wr && first) begin
      case (off)
        0: if (q.size() > 0) begin mData = q[0]; doPop = 1'b1; end else mData = 32'd0;
        1: mData = 32'(mDrop * 256 + (q.size() % 64) * 4 + (mOvf ? 2 : 0) + (full ? 1 : 0));
`ifdef RGU_RESULT_IRQ_EN
        3: mData = 32'(mThresh);
`endif
        default: mData = 32'd0;
      endcase
    end
    @(posedge iClock); #1;
    prevSel = sel; prevAddr = addr;
    if (isCtrl && wdata[0]) begin
      q.delete();
    end else begin
      if (doPop) void'(q.pop_front());
      if (push) begin
        if (!full || doPop) q.push_back(pdata);
        else begin mOvf = 1'b1; if (mDrop < 255) mDrop++; end
      end
    end
    if (isCtrl && wdata[1]) begin mOvf = 1'b0; mDrop = 0; end
`ifdef RGU_RESULT_IRQ_EN
    if (hit && wr && off == 3) mThresh = int'(wdata[AW:0]);
`endif
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic clean_up();
    step(1'b0, 32'd0, 1'b1, 1'b1, A_CTRL, 32'd3);
    idle();
  endtask

  task automatic test_reset();
    #1 iReset = 1'b0;
    #2;
    nVec++; if (oUartData !== 32'd0) begin nFail++; $display("FAIL reset_data: got %h want 0", oUartData); end
    nVec++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL reset_empty: got %b want 1", oEmpty); end
    nVec++; if (oFull !== 1'b0 || oOverflow !== 1'b0) begin nFail++; $display("FAIL reset_flags: full %b ovf %b want 0 0", oFull, oOverflow); end
    model_reset();
    @(negedge iClock) iReset = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0, A_THR, 32'd0);
    nVec++; if (oUartData !== mData) begin nFail++; $display("FAIL reset_thresh: got %h want %h", oUartData, mData); end
    idle();
  endtask

  task automatic test_basic();
    clean_up();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA0000001 + 32'(i), 1'b0, 1'b0, 8'd0, 32'd0);
    nVec++; if (oEmpty !== 1'b0) begin nFail++; $display("FAIL basic_notempty: got %b want 0", oEmpty); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
      nVec++;
      if (oUartData !== ((i < 3) ? 32'hA0000001 + 32'(i) : 32'd0)) begin
        nFail++; $display("FAIL basic_read%0d: got %h want %h", i, oUartData, (i < 3) ? 32'hA0000001 + 32'(i) : 32'd0);
      end
      idle();
    end
    nVec++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL basic_empty: got %b want 1", oEmpty); end
  endtask

  task automatic test_overflow();
    clean_up();
    for (int i = 0; i < 18; i++) step(1'b1, $urandom, 1'b0, 1'b0, 8'd0, 32'd0);
    nVec++; if (oFull !== 1'b1 || oOverflow !== 1'b1) begin nFail++; $display("FAIL ovf_flags: full %b ovf %b want 1 1", oFull, oOverflow); end
    step(1'b0, 32'd0, 1'b1, 1'b0, A_STAT, 32'd0);
    nVec++; if (oUartData !== 32'h0000_0243) begin nFail++; $display("FAIL ovf_status: got %h want 00000243", oUartData); end
    idle();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
      nVec++; if (oUartData !== mData) begin nFail++; $display("FAIL ovf_drain%0d: got %h want %h", i, oUartData, mData); end
      idle();
    end
    step(1'b0, 32'd0, 1'b1, 1'b1, A_CTRL, 32'd2);
    idle();
    nVec++; if (oOverflow !== 1'b0 || oEmpty !== 1'b1) begin nFail++; $display("FAIL ovf_clear: ovf %b empty %b want 0 1", oOverflow, oEmpty); end
    step(1'b0, 32'd0, 1'b1, 1'b0, A_STAT, 32'd0);
    nVec++; if (oUartData !== 32'd0) begin nFail++; $display("FAIL ovf_status_clr: got %h want 0", oUartData); end
    idle();
  endtask

  task automatic test_held_select();
    clean_up();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0000000 + 32'(i), 1'b0, 1'b0, 8'd0, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
    nVec++; if (oUartData !== 32'hB0000000) begin nFail++; $display("FAIL held_data: got %h want b0000000", oUartData); end
    idle();
    step(1'b0, 32'd0, 1'b1, 1'b0, A_STAT, 32'd0);
    nVec++; if (oUartData !== 32'h0000_000C) begin nFail++; $display("FAIL held_count: got %h want 0000000c", oUartData); end
    idle();
  endtask

  task automatic test_full_pushpop();
    clean_up();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0, 8'd0, 32'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
      idle();
    end
    for (int i = 0; i < 16; i++) step(1'b1, 32'hC0000000 + 32'(i), 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 32'hC0000010, 1'b1, 1'b0, A_DATA, 32'd0);
    nVec++; if (oFull !== 1'b1 || oOverflow !== 1'b0) begin nFail++; $display("FAIL pp_flags: full %b ovf %b want 1 0", oFull, oOverflow); end
    nVec++; if (oUartData !== 32'hC0000000) begin nFail++; $display("FAIL pp_data: got %h want c0000000", oUartData); end
    idle();
    step(1'b0, 32'd0, 1'b1, 1'b0, A_STAT, 32'd0);
    nVec++; if (oUartData !== 32'h0000_0041) begin nFail++; $display("FAIL pp_status: got %h want 00000041", oUartData); end
    idle();
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
      nVec++; if (oUartData !== 32'hC0000000 + 32'(i)) begin nFail++; $display("FAIL pp_drain%0d: got %h want %h", i, oUartData, 32'hC0000000 + 32'(i)); end
      idle();
    end
  endtask

  task automatic test_flush();
    clean_up();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 32'h12345678, 1'b1, 1'b1, A_CTRL, 32'd1);
    nVec++; if (oEmpty !== 1'b1 || oFull !== 1'b0 || oOverflow !== 1'b0) begin nFail++; $display("FAIL flush_flags: empty %b full %b ovf %b want 1 0 0", oEmpty, oFull, oOverflow); end
    idle();
    step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
    nVec++; if (oUartData !== 32'd0) begin nFail++; $display("FAIL flush_read: got %h want 0", oUartData); end
    idle();
  endtask

`ifdef RGU_RESULT_IRQ_EN
  task automatic test_irq();
    clean_up();
    step(1'b0, 32'd0, 1'b1, 1'b1, A_THR, 32'd4);
    idle();
    for (int i = 0; i < 4; i++) begin
      nVec++; if (oIrq !== 1'b0) begin nFail++; $display("FAIL irq_early%0d: got %b want 0", i, oIrq); end
      step(1'b1, $urandom, 1'b0, 1'b0, 8'd0, 32'd0);
    end
    nVec++; if (oIrq !== 1'b1) begin nFail++; $display("FAIL irq_rise: got %b want 1", oIrq); end
    step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
    nVec++; if (oIrq !== 1'b0) begin nFail++; $display("FAIL irq_fall: got %b want 0", oIrq); end
    idle();
  endtask
`endif

  task automatic test_async_reset();
    clean_up();
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, $urandom, 1'b1, 1'b0, A_DATA, 32'd0);
    step(1'b1, $urandom, 1'b0, 1'b0, 8'd0, 32'd0);
    #3 iReset = 1'b0;
    #1;
    nVec++; if (oUartData !== 32'd0 || oEmpty !== 1'b1 || oFull !== 1'b0 || oOverflow !== 1'b0) begin
      nFail++; $display("FAIL async_reset: data %h empty %b full %b ovf %b", oUartData, oEmpty, oFull, oOverflow);
    end
`ifdef RGU_RESULT_IRQ_EN
    nVec++; if (oIrq !== 1'b0) begin nFail++; $display("FAIL async_irq: got %b want 0", oIrq); end
`endif
    iFifoPush = 1'b0; iUartSelected = 1'b0;
    model_reset();
    #2 iReset = 1'b1;
    step(1'b1, 32'h0000_5A5A, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, A_DATA, 32'd0);
    nVec++; if (oUartData !== 32'h0000_5A5A) begin nFail++; $display("FAIL async_first_push: got %h want 00005a5a", oUartData); end
    idle();
  endtask

  task automatic test_random();
    bit push, sel, wr;
    logic [7:0] addr;
    logic [31:0] wdata;
    int r;
    clean_up();
    for (int c = 0; c < 600; c++) begin
      push = ($urandom % 3) != 0;
      sel  = ($urandom % 4) != 0;
      r    = $urandom % 6;
      addr = (r < 4) ? A_DATA + 8'(r) : ((r == 4) ? 8'h44 : 8'h3F);
      wr   = ($urandom % 8) == 0;
      wdata = 32'd0;
      if (wr && addr == A_CTRL) begin
        wdata = 32'($urandom % 4);
        if (($urandom % 4) != 0) wdata[0] = 1'b0;
        if (wdata[1]) push = 1'b0;
      end else if (wr) begin
        wdata = 32'($urandom % 20);
      end
      step(push, $urandom, sel, wr, addr, wdata);
      nVec++; if (oUartData !== mData) begin nFail++; $display("FAIL rnd_data c%0d: got %h want %h", c, oUartData, mData); end
      nVec++; if (oEmpty !== (q.size() == 0) || oFull !== (q.size() == DEPTH)) begin
        nFail++; $display("FAIL rnd_flags c%0d: empty %b full %b model count %0d", c, oEmpty, oFull, q.size());
      end
      nVec++; if (oOverflow !== mOvf) begin nFail++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, oOverflow, mOvf); end
`ifdef RGU_RESULT_IRQ_EN
      nVec++; if (oIrq !== (mThresh != 0 && q.size() >= mThresh)) begin
        nFail++; $display("FAIL rnd_irq c%0d: got %b count %0d thresh %0d", c, oIrq, q.size(), mThresh);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_held_select();
    test_full_pushpop();
    test_flush();
`ifdef RGU_RESULT_IRQ_EN
    test_irq();
`endif
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
